pe_dot_ctrl: RTL and testbench
==============================

// Module: pe_dot_ctrl
// PURPOSE
//  Sequencer for one pe_unit MAC: computes a signed dot product of two length-N int8 vectors held in
//  two operand SRAMs (1-cycle read latency). Clears the PE, streams operand pairs with a one-cycle
//  pe_ready per element, captures the 24-bit accumulator, presents it on a valid/ready result port.
//  Sits between the NPU top-level command logic and a single pe_unit instance.
// PARAMETERS
//  ADDR_W  8   operand SRAM address width; max vector length 2**ADDR_W
//  DATA_W  8   signed operand width (matches pe_unit in_data1/in_data2)
//  ACC_W   24  signed accumulator/result width (matches pe_unit outdata)
// PORTS
//  clk          in   1         clock, all state on rising edge
//  rst_n        in   1         asynchronous active-low reset
//  start        in   1         command strobe, sampled only in IDLE
//  vec_len      in   ADDR_W+1  element count N, 0..2**ADDR_W, captured with start
//  base_a       in   ADDR_W    SRAM A start address, captured with start
//  base_b       in   ADDR_W    SRAM B start address, captured with start
//  busy         out  1         high from accepted start until result handshake completes
//  rd_en        out  1         SRAM read strobe (both SRAMs)
//  rd_addr_a    out  ADDR_W    SRAM A read address
//  rd_addr_b    out  ADDR_W    SRAM B read address
//  rd_data_a    in   DATA_W    SRAM A data, valid cycle after rd_en
//  rd_data_b    in   DATA_W    SRAM B data, valid cycle after rd_en
//  pe_clr       out  1         synchronous accumulator clear to PE
//  pe_ready     out  1         PE accumulate enable, one cycle per element
//  pe_in_data1  out  DATA_W    operand A to PE (= rd_data_a)
//  pe_in_data2  out  DATA_W    operand B to PE (= rd_data_b)
//  pe_outdata   in   ACC_W     PE accumulator value
//  res_valid    out  1         result available
//  res_ready    in   1         consumer accepts result
//  res_data     out  ACC_W     signed dot-product result
// BEHAVIOUR
//  - Reset: state IDLE; busy, rd_en, pe_clr, pe_ready, res_valid = 0; rd_addr_*, res_data, count = 0.
//  - Async reset mid-operation aborts immediately; no partial result; PE shares rst_n.
//  - FSM: IDLE -start-> CLEAR (pe_clr=1, 1 cycle) -> RUN if N>0 else DRAIN1.
//    RUN: rd_en=1, addrs base+i, i=0..N-1, one per cycle; last issue -> DRAIN1 -> DRAIN2 -> DONE.
//    DRAIN2 registers pe_outdata into res_data. DONE: res_valid=1 until res_valid&&res_ready -> IDLE.
//  - pe_ready = rd_en delayed 1 cycle; pe_in_data* pass SRAM data combinationally, aligned with pe_ready.
//  - Latency: start sampled cycle 0 -> res_valid first high cycle N+4 (N=0 -> cycle 4, result 0).
//  - Address arithmetic is modulo 2**ADDR_W (base 255 + 1 wraps to 0); count is ADDR_W+1 bits.
//  - start outside IDLE is ignored (no queueing); vec_len/base sampled only with accepted start.
//  - Result held stable while res_valid && !res_ready; back-to-back: start may be accepted the cycle
//    after the handshake (IDLE), not in the same cycle.
//  - No overflow detection: ACC_W=24 covers N<=256 of int8*int8 products.
// CONFIGURATION
//  PE_DOT_CTRL_RELU_EN defined: res_data = (captured < 0) ? 0 : captured.
//  Not defined: res_data = captured signed value unmodified. Timing identical both ways.
// STRUCTURE
//  npu_pkg: state encoding localparams (IDLE, CLEAR, RUN, DRAIN1, DRAIN2, DONE), default DATA_W/ACC_W.
//  Single flat module; address/count generator inline, no sub-module.
// TESTING
//  1 base 0/0, N=3, A={2,-1,3}, B={3,2,4} -> res_data=16, res_valid at cycle 7, 3 pe_ready pulses.
//  2 N=1, A={-1}, B={2} -> res_data=-2 (0x FFFFFE); with PE_DOT_CTRL_RELU_EN -> 0.
//  3 N=0 -> pe_clr once, zero rd_en/pe_ready, res_valid at cycle 4 with res_data=0.
//  4 base_a=254, N=4 -> rd_addr_a sequence 254,255,0,1; result matches reference model.
//  5 hold res_ready=0 for 5 cycles, pulse start meanwhile -> res_data stable, start ignored, busy=1.
//  6 assert rst_n=0 during RUN -> all outputs to reset values; next start with N=2 gives correct result.

Source files
------------

// File: rtl/pe_dot_ctrl_pkg.sv
// Shared types and default widths for the pe_dot_ctrl dot-product sequencer.
package pe_dot_ctrl_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;
    localparam int ACC_W_DEF  = 24;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_RUN    = 3'd2,
        ST_DRAIN1 = 3'd3,
        ST_DRAIN2 = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

endpackage

// File: rtl/pe_dot_ctrl.sv
// Sequences one pe_unit through a signed int8 dot product read from two operand SRAMs.
// Optional: define PE_DOT_CTRL_RELU_EN to clamp negative results to zero (timing unchanged).
module pe_dot_ctrl
    import pe_dot_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   vec_len,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    output logic              busy,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr_a,
    output logic [ADDR_W-1:0] rd_addr_b,
    input  logic [DATA_W-1:0] rd_data_a,
    input  logic [DATA_W-1:0] rd_data_b,
    output logic              pe_clr,
    output logic              pe_ready,
    output logic [DATA_W-1:0] pe_in_data1,
    output logic [DATA_W-1:0] pe_in_data2,
    input  logic [ACC_W-1:0]  pe_outdata,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_data
);

    localparam int CNT_W = ADDR_W + 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  count_inc;
    logic [ADDR_W-1:0] addr_a_q, addr_a_d;
    logic [ADDR_W-1:0] addr_b_q, addr_b_d;
    logic              pe_ready_q;
    logic [ACC_W-1:0]  res_q, res_d;
    logic [ACC_W-1:0]  res_capt;

    assign count_inc = count_q + CNT_W'(1);

`ifdef PE_DOT_CTRL_RELU_EN
    assign res_capt = pe_outdata[ACC_W-1] ? '0 : pe_outdata;
`else
    assign res_capt = pe_outdata;
`endif

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        count_d   = count_q;
        addr_a_d  = addr_a_q;
        addr_b_d  = addr_b_q;
        res_d     = res_q;
        busy      = 1'b1;
        rd_en     = 1'b0;
        pe_clr    = 1'b0;
        res_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    len_d    = vec_len;
                    count_d  = '0;
                    addr_a_d = base_a;
                    addr_b_d = base_b;
                    state_d  = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                pe_clr  = 1'b1;
                state_d = (len_q == '0) ? ST_DRAIN1 : ST_RUN;
            end
            ST_RUN: begin
                rd_en    = 1'b1;
                count_d  = count_inc;
                addr_a_d = addr_a_q + ADDR_W'(1);
                addr_b_d = addr_b_q + ADDR_W'(1);
                if (count_inc == len_q) state_d = ST_DRAIN1;
            end
            // DRAIN1 lets the last pe_ready land; DRAIN2 sees the final accumulator.
            ST_DRAIN1: state_d = ST_DRAIN2;
            ST_DRAIN2: begin
                res_d   = res_capt;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                res_valid = 1'b1;
                if (res_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            count_q    <= '0;
            addr_a_q   <= '0;
            addr_b_q   <= '0;
            pe_ready_q <= 1'b0;
            res_q      <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            count_q    <= count_d;
            addr_a_q   <= addr_a_d;
            addr_b_q   <= addr_b_d;
            pe_ready_q <= rd_en;
            res_q      <= res_d;
        end
    end

    assign rd_addr_a   = addr_a_q;
    assign rd_addr_b   = addr_b_q;
    assign pe_ready    = pe_ready_q;
    assign pe_in_data1 = rd_data_a;
    assign pe_in_data2 = rd_data_b;
    assign res_data    = res_q;

endmodule

// File: tb/tb_pe_dot_ctrl.sv
// Directed bench for pe_dot_ctrl with behavioural SRAM and PE models.
module tb_pe_dot_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [8:0]  vec_len;
    logic [7:0]  base_a, base_b;
    logic        busy, rd_en, pe_clr, pe_ready, res_valid, res_ready;
    logic [7:0]  rd_addr_a, rd_addr_b;
    logic [7:0]  rd_data_a, rd_data_b;
    logic [7:0]  pe_in_data1, pe_in_data2;
    logic [23:0] pe_outdata, res_data;

    logic signed [23:0] pe_acc;
    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];

    int checks = 0;
    int failures = 0;
    int pr_cnt, re_cnt, clr_cnt, alog_n;
    int alog [8];

    always #5 clk = ~clk;

    pe_dot_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .vec_len(vec_len),
        .base_a(base_a), .base_b(base_b), .busy(busy), .rd_en(rd_en),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .pe_clr(pe_clr), .pe_ready(pe_ready),
        .pe_in_data1(pe_in_data1), .pe_in_data2(pe_in_data2),
        .pe_outdata(pe_outdata), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data)
    );

    always @(posedge clk) begin
        if (rd_en) begin
            rd_data_a <= mem_a[rd_addr_a];
            rd_data_b <= mem_b[rd_addr_b];
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)        pe_acc <= '0;
        else if (pe_clr)   pe_acc <= '0;
        else if (pe_ready) pe_acc <= pe_acc + $signed(pe_in_data1) * $signed(pe_in_data2);
    end
    assign pe_outdata = pe_acc;

    always @(negedge clk) begin
        if (pe_ready) pr_cnt++;
        if (pe_clr)   clr_cnt++;
        if (rd_en) begin
            re_cnt++;
            if (alog_n < 8) alog[alog_n] = int'(rd_addr_a);
            alog_n++;
        end
    end

    typedef struct {
        int len;
        int ba;
        int bb;
        int a[4];
        int b[4];
        int exp;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int exp_out(input int v);
`ifdef PE_DOT_CTRL_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    task automatic load_mem(input int len, input int ba, input int bb,
                            input int a[4], input int b[4]);
        for (int i = 0; i < len; i++) begin
            mem_a[(ba + i) % 256] = 8'(a[i]);
            mem_b[(bb + i) % 256] = 8'(b[i]);
        end
    endtask

    task automatic start_op(input int len, input int ba, input int bb);
        @(negedge clk);
        pr_cnt = 0; re_cnt = 0; clr_cnt = 0; alog_n = 0;
        vec_len = len[8:0];
        base_a  = ba[7:0];
        base_b  = bb[7:0];
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    // Called in cycle 1 (the CLEAR cycle); returns at the negedge where res_valid is first seen.
    task automatic wait_result(input string nm, input int len, input int expv);
        int c;
        c = 1;
        while (!res_valid && c < len + 40) begin
            @(negedge clk);
            c++;
        end
        chk({nm, ".latency"}, c, len + 4);
        chk({nm, ".res_data"}, longint'($signed(res_data)), exp_out(expv));
        chk({nm, ".pe_ready_pulses"}, pr_cnt, len);
        chk({nm, ".rd_en_cycles"}, re_cnt, len);
        chk({nm, ".pe_clr_pulses"}, clr_cnt, 1);
    endtask

    task automatic handshake(input string nm);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk({nm, ".busy_after_hs"}, busy, 0);
        chk({nm, ".valid_after_hs"}, res_valid, 0);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, ".busy"}, busy, 0);
        chk({nm, ".rd_en"}, rd_en, 0);
        chk({nm, ".pe_clr"}, pe_clr, 0);
        chk({nm, ".pe_ready"}, pe_ready, 0);
        chk({nm, ".res_valid"}, res_valid, 0);
        chk({nm, ".rd_addr_a"}, rd_addr_a, 0);
        chk({nm, ".rd_addr_b"}, rd_addr_b, 0);
        chk({nm, ".res_data"}, res_data, 0);
    endtask

    initial begin
        int a6 [4];
        int b6 [4];
        int v;

        vecs[0] = '{3,   0,   0, '{2, -1, 3, 0},       '{3, 2, 4, 0},          16};
        vecs[1] = '{1,   5,   9, '{-1, 0, 0, 0},       '{2, 0, 0, 0},          -2};
        vecs[2] = '{0,   0,   0, '{0, 0, 0, 0},        '{0, 0, 0, 0},          0};
        vecs[3] = '{4, 254,  10, '{5, -7, 127, -128},  '{-3, 4, 127, -128},    32470};
        vecs[4] = '{2, 255, 255, '{-128, -128, 0, 0},  '{127, -128, 0, 0},     128};

        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 8'h00;
            mem_b[i] = 8'h00;
        end
        rst_n = 1'b0; start = 1'b0; res_ready = 1'b0;
        vec_len = '0; base_a = '0; base_b = '0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        for (int k = 0; k < 5; k++) begin
            string nm;
            nm = $sformatf("vec%0d", k);
            load_mem(vecs[k].len, vecs[k].ba, vecs[k].bb, vecs[k].a, vecs[k].b);
            start_op(vecs[k].len, vecs[k].ba, vecs[k].bb);
            wait_result(nm, vecs[k].len, vecs[k].exp);
            if (k == 3) begin
                chk("wrap.addr0", alog[0], 254);
                chk("wrap.addr1", alog[1], 255);
                chk("wrap.addr2", alog[2], 0);
                chk("wrap.addr3", alog[3], 1);
            end
            handshake(nm);
        end

        // Back-pressure: result must hold while a stray start is ignored.
        load_mem(vecs[0].len, vecs[0].ba, vecs[0].bb, vecs[0].a, vecs[0].b);
        start_op(3, 0, 0);
        wait_result("hold", 3, 16);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                start = 1'b1; vec_len = 9'd2; base_a = 8'd40; base_b = 8'd40;
            end
            if (i == 2) start = 1'b0;
            @(negedge clk);
            chk($sformatf("hold.res_data%0d", i), longint'($signed(res_data)), exp_out(16));
            chk($sformatf("hold.valid%0d", i), res_valid, 1);
            chk($sformatf("hold.busy%0d", i), busy, 1);
        end
        handshake("hold");
        v = 0;
        repeat (3) begin
            @(negedge clk);
            if (busy) v++;
        end
        chk("hold.no_queued_start", v, 0);

        // Reset in the middle of RUN, then a clean operation.
        a6 = '{1, 2, 3, 4};
        b6 = '{1, 1, 1, 1};
        load_mem(4, 20, 20, a6, b6);
        start_op(4, 20, 20);
        @(negedge clk);
        chk("abort.in_run", rd_en, 1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        a6 = '{7, -3, 0, 0};
        b6 = '{6, 5, 0, 0};
        load_mem(2, 40, 40, a6, b6);
        start_op(2, 40, 40);
        wait_result("after_abort", 2, 27);
        handshake("after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
